// File: rtl/spi_reg_bridge.sv
// SPI slave (mode 0) that decodes one instr/addr/data frame into a single register-bus access.
// SPI pins are oversampled on clk; MOSI is taken on sck rise and MISO is updated on sck fall.
module spi_reg_bridge #(
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT     = 48,
    parameter logic [7:0] WRITE_INSTR = 8'h00,
    parameter logic [7:0] READ_INSTR  = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INSTR, S_GAP, S_ADDR, S_WDATA,
        S_DUMMY, S_RDATA, S_STATUS, S_DONE, S_ABORT
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic        sck_d;
    logic        sck_s, ss_s, mosi_s, rise, fall;
    logic [4:0]  cnt, cnt_n;
    logic [30:0] shreg;
    logic [31:0] rx_word, addr_hold, tx, rdata_q;
    logic        is_read;
    logic        st_bad, st_tmo, st_err, st_ok;
    logic [7:0]  status;
    logic [TW-1:0] tcnt;
    logic        frame_start, latch_instr, latch_addr, issue, load_rd, load_st, set_bad;

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign ss_s    = ss_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    // Edges are ignored while the slave is deselected.
    assign rise    = sck_s & ~sck_d & ~ss_s;
    assign fall    = ~sck_s & sck_d & ~ss_s;
    assign rx_word = {shreg, mosi_s};
    assign status  = {4'b0000, st_bad, st_tmo, st_err, st_ok};
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        frame_start = 1'b0;
        latch_instr = 1'b0;
        latch_addr  = 1'b0;
        issue       = 1'b0;
        load_rd     = 1'b0;
        load_st     = 1'b0;
        set_bad     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!ss_s) begin
                    state_n     = S_INSTR;
                    cnt_n       = '0;
                    frame_start = 1'b1;
                end
            end
            S_ABORT: begin
                if (!bus_req) state_n = S_IDLE;
            end
            S_DONE: begin
                if (ss_s) state_n = bus_req ? S_ABORT : S_IDLE;
            end
            default: begin
                // An access already on the bus must finish before returning to IDLE.
                if (ss_s) begin
                    state_n = bus_req ? S_ABORT : S_IDLE;
                    cnt_n   = '0;
                end else if (rise) begin
                    cnt_n = cnt + 5'd1;
                    case (state)
                        S_INSTR: begin
                            if (cnt == 5'd7) begin
                                cnt_n       = '0;
                                latch_instr = 1'b1;
                                if (rx_word[7:0] == WRITE_INSTR || rx_word[7:0] == READ_INSTR) begin
                                    state_n = S_GAP;
                                end else begin
                                    state_n = S_DONE;
                                    set_bad = 1'b1;
                                end
                            end
                        end
                        S_GAP: begin
                            cnt_n   = '0;
                            state_n = S_ADDR;
                        end
                        S_ADDR: begin
                            if (cnt == 5'd31) begin
                                cnt_n      = '0;
                                latch_addr = 1'b1;
                                if (is_read) begin
                                    issue   = 1'b1;
                                    state_n = S_DUMMY;
                                end else begin
                                    state_n = S_WDATA;
                                end
                            end
                        end
                        S_WDATA: begin
                            if (cnt == 5'd31) begin
                                cnt_n   = '0;
                                issue   = 1'b1;
                                state_n = S_DUMMY;
                            end
                        end
                        S_DUMMY: begin
                            if (cnt == 5'd7) begin
                                cnt_n = '0;
                                if (is_read) begin
                                    load_rd = 1'b1;
                                    state_n = S_RDATA;
                                end else begin
                                    load_st = 1'b1;
                                    state_n = S_STATUS;
                                end
                            end
                        end
                        S_RDATA: begin
                            if (cnt == 5'd31) begin
                                cnt_n   = '0;
                                load_st = 1'b1;
                                state_n = S_STATUS;
                            end
                        end
                        S_STATUS: begin
                            if (cnt == 5'd7) begin
                                cnt_n   = '0;
                                state_n = S_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            is_read   <= 1'b0;
            addr_hold <= '0;
        end else begin
            if (rise)        shreg     <= rx_word[30:0];
            if (latch_instr) is_read   <= (rx_word[7:0] == READ_INSTR);
            if (latch_addr)  addr_hold <= rx_word;
        end
    end

    // Bus access: request held until ready or the timeout counter expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            tcnt      <= '0;
            rdata_q   <= '0;
            st_bad    <= 1'b0;
            st_tmo    <= 1'b0;
            st_err    <= 1'b0;
            st_ok     <= 1'b0;
        end else begin
            if (frame_start) begin
                rdata_q <= '0;
                st_bad  <= 1'b0;
                st_tmo  <= 1'b0;
                st_err  <= 1'b0;
                st_ok   <= 1'b0;
            end
            if (set_bad) st_bad <= 1'b1;
            if (bus_req) begin
                if (bus_ready) begin
                    bus_req <= 1'b0;
                    st_err  <= bus_err;
                    st_ok   <= ~bus_err;
                    if (!bus_we) rdata_q <= bus_rdata;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    bus_req <= 1'b0;
                    st_tmo  <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else if (issue) begin
                bus_req  <= 1'b1;
                tcnt     <= '0;
                bus_we   <= ~is_read;
                bus_addr <= is_read ? rx_word : addr_hold;
                if (!is_read) bus_wdata <= rx_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx       <= '0;
            spi_miso <= 1'b0;
        end else begin
            if (load_rd) begin
                tx <= rdata_q;
            end else if (load_st) begin
                tx <= {status, 24'h000000};
            end else if (fall && (state == S_RDATA || state == S_STATUS)) begin
                tx <= {tx[30:0], 1'b0};
            end
            if (fall) begin
                spi_miso <= (state == S_RDATA || state == S_STATUS) ? tx[31] : 1'b0;
            end else if (state == S_IDLE || state == S_DONE || state == S_ABORT) begin
                spi_miso <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: SPI master driver, bus responder, access scoreboard and frame-level model.
module tb_spi_reg_bridge;
    localparam int         TIMEOUT = 48;
    localparam int         HALF    = 8;
    localparam logic [7:0] WR      = 8'h00;
    localparam logic [7:0] RD      = 8'h01;

    logic        clk, rst;
    logic        spi_sck, spi_ss_n, spi_mosi, spi_miso;
    logic        bus_req, bus_we, bus_ready, bus_err, busy;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    spi_reg_bridge #(
        .SYNC_STAGES(2), .TIMEOUT(TIMEOUT), .WRITE_INSTR(WR), .READ_INSTR(RD)
    ) dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .bus_err(bus_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [72:0] exp_q[$];   // {we, addr, wdata, expected cycles bus_req stays high}
    int          resp_lat = 0;  // 0 = never answer
    logic [31:0] resp_rdata = '0;
    logic        resp_err = 1'b0;
    logic        abandon = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_dur(input int lat);
        return (lat < 1 || lat > TIMEOUT) ? TIMEOUT : lat;
    endfunction

    function automatic logic [7:0] exp_status(input int lat, input logic err);
        if (lat < 1 || lat > TIMEOUT) return 8'h04;
        return err ? 8'h02 : 8'h01;
    endfunction

    // Bus responder: answers lat cycles after bus_req rises, otherwise drives junk.
    initial begin : responder
        int   cyc;
        logic served;
        cyc = 0;
        served = 1'b0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        bus_err = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req && !served) begin
                cyc++;
                if (cyc == resp_lat) begin
                    bus_ready = 1'b1;
                    bus_rdata = resp_rdata;
                    bus_err   = resp_err;
                    served    = 1'b1;
                end else begin
                    bus_ready = 1'b0;
                    bus_rdata = $urandom;
                    bus_err   = 1'($urandom_range(0, 1));
                end
            end else begin
                bus_ready = 1'b0;
                bus_rdata = $urandom;
                bus_err   = 1'($urandom_range(0, 1));
                if (!bus_req) begin
                    cyc = 0;
                    served = 1'b0;
                end
            end
        end
    end

    // Scoreboard for bus accesses, evaluated every cycle.
    initial begin : monitor
        logic        prev, cur_valid, stable, busy_ok;
        logic [72:0] cur;
        logic [64:0] snap;
        int          dur;
        prev = 1'b0; cur_valid = 1'b0; stable = 1'b1; busy_ok = 1'b1; cur = '0; snap = '0; dur = 0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev) begin
                dur = 1;
                stable = 1'b1;
                busy_ok = busy;
                snap = {bus_we, bus_addr, bus_wdata};
                if (exp_q.size() == 0) begin
                    cur_valid = 1'b0;
                    check("unexpected_req", 32'(bus_req), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("req_we", 32'(bus_we), 32'(cur[72]));
                    check("req_addr", bus_addr, cur[71:40]);
                    if (cur[72]) check("req_wdata", bus_wdata, cur[39:8]);
                end
            end else if (bus_req) begin
                dur++;
                if ({bus_we, bus_addr, bus_wdata} !== snap) stable = 1'b0;
                if (!busy) busy_ok = 1'b0;
            end else if (prev && cur_valid) begin
                if (!abandon) check("req_cycles", dur, 32'(cur[7:0]));
                check("req_stable", 32'(stable), 32'd1);
                check("busy_during_req", 32'(busy_ok), 32'd1);
                cur_valid = 1'b0;
            end
            prev = bus_req;
        end
    end

    // SPI master: sends nbits of the frame MSB first, collects MISO on every rise.
    task automatic run_frame(input logic [7:0] instr, input logic [31:0] addr, input logic [31:0] data,
                             input int nbits, output logic [88:0] mb);
        logic [88:0] v;
        v = {instr, 1'b0, addr, data, 16'h0000};
        mb = '0;
        @(negedge clk);
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check("busy_rise", 32'(busy), 32'd1);
        for (int k = 0; k < nbits; k++) begin
            spi_mosi = v[88-k];
            repeat (HALF) @(negedge clk);
            mb[88-k] = spi_miso;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_ss_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_access(input logic [7:0] instr, input logic [31:0] addr, input logic [31:0] data,
                             input int lat, input logic err, input logic [31:0] rdata,
                             output logic [31:0] got_rd, output logic [7:0] got_st);
        logic [88:0] mb;
        logic        valid, rd;
        valid = (instr == WR) || (instr == RD);
        rd = (instr == RD);
        resp_lat = lat;
        resp_rdata = rdata;
        resp_err = err;
        if (valid) exp_q.push_back({~rd, addr, data, 8'(exp_dur(lat))});
        run_frame(instr, addr, data, 89, mb);
        wait_idle();
        got_rd = mb[39:8];
        got_st = mb[7:0];
        if (!valid) begin
            check("bad_instr_miso", 32'(|mb), 32'd0);
        end else if (rd) begin
            check("rd_data", got_rd, (lat >= 1 && lat <= TIMEOUT) ? rdata : 32'h0);
            check("rd_status", 32'(got_st), 32'(exp_status(lat, err)));
            check("rd_idle_miso", 32'(|mb[88:40]), 32'd0);
        end else begin
            check("wr_status", 32'(got_st), 32'(exp_status(lat, err)));
            check("wr_idle_miso", 32'(|mb[88:8]), 32'd0);
        end
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin : watchdog
        #3000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : main
        logic [31:0] rd_v;
        logic [7:0]  st_v;
        logic [88:0] mb;
        logic [7:0]  instr;
        int          r, lat;
        rst = 1'b1;
        spi_sck = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        do_access(WR, 32'h0000_0010, 32'hDEAD_BEEF, 3, 1'b0, 32'h0, rd_v, st_v);
        check("lit_wr_status", 32'(st_v), 32'h01);
        do_access(RD, 32'h0000_0024, 32'h0, 5, 1'b0, 32'h1234_5678, rd_v, st_v);
        check("lit_rd_data", rd_v, 32'h1234_5678);
        check("lit_rd_status", 32'(st_v), 32'h01);
        do_access(RD, 32'h0000_0030, 32'h0, 4, 1'b1, 32'hCAFE_F00D, rd_v, st_v);
        check("lit_err_data", rd_v, 32'hCAFE_F00D);
        check("lit_err_status", 32'(st_v), 32'h02);
        do_access(RD, 32'h0000_0040, 32'h0, 0, 1'b0, 32'h5555_AAAA, rd_v, st_v);
        check("lit_tmo_data", rd_v, 32'h0000_0000);
        check("lit_tmo_status", 32'(st_v), 32'h04);
        do_access(8'h55, 32'h0000_0050, 32'hFFFF_FFFF, 3, 1'b0, 32'h0, rd_v, st_v);

        // Boundary latencies around the timeout.
        do_access(RD, 32'h0000_0060, 32'h0, 1, 1'b0, 32'h8000_0001, rd_v, st_v);
        do_access(RD, 32'h0000_0064, 32'h0, TIMEOUT, 1'b0, 32'hA5A5_5A5A, rd_v, st_v);
        do_access(RD, 32'h0000_0068, 32'h0, TIMEOUT + 1, 1'b0, 32'hFFFF_0000, rd_v, st_v);
        do_access(WR, 32'h0000_006C, 32'h0123_4567, TIMEOUT, 1'b1, 32'h0, rd_v, st_v);

        // Frame dropped after 20 address bits, then a complete write.
        run_frame(WR, 32'hAAAA_5555, 32'h0000_0001, 29, mb);
        wait_idle();
        check("abort_miso", 32'(|mb), 32'd0);
        do_access(WR, 32'h0000_0070, 32'h1357_9BDF, 6, 1'b0, 32'h0, rd_v, st_v);

        // Deselect while a read is on the bus: the access must still complete.
        resp_lat = 45;
        resp_rdata = 32'h0BAD_F00D;
        resp_err = 1'b0;
        exp_q.push_back({1'b0, 32'h0000_0080, 32'h0, 8'd45});
        run_frame(RD, 32'h0000_0080, 32'h0, 42, mb);
        repeat (6) @(negedge clk);
        check("abort_req_held", 32'(bus_req), 32'd1);
        check("abort_busy_held", 32'(busy), 32'd1);
        wait_idle();
        check("abort_queue", exp_q.size(), 32'd0);

        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            instr = (r < 5) ? WR : (r < 9) ? RD : 8'($urandom_range(2, 255));
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : (r == 1) ? $urandom_range(TIMEOUT - 3, TIMEOUT + 4) : $urandom_range(1, 20);
            do_access(instr, $urandom, $urandom, lat, 1'($urandom_range(0, 1)), $urandom, rd_v, st_v);
        end

        // Asynchronous reset while an access is outstanding.
        resp_lat = 0;
        abandon = 1'b1;
        exp_q.push_back({1'b0, 32'h0000_0090, 32'h0, 8'(TIMEOUT)});
        run_frame(RD, 32'h0000_0090, 32'h0, 42, mb);
        check("pre_rst_req", 32'(bus_req), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_req", 32'(bus_req), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_miso", 32'(spi_miso), 32'd0);
        check("async_rst_addr", bus_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        abandon = 1'b0;
        exp_q.delete();
        do_access(WR, 32'h0000_00A0, 32'hFEED_FACE, 2, 1'b0, 32'h0, rd_v, st_v);
        check("recover_status", 32'(st_v), 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
